// File: rtl/vx_mem_perf_monitor.sv
// Per-channel memory performance monitor: lane-level read/write/response counters,
// outstanding-read tracking and a registered channel-indexed readout. Optional macro: MEM_PERF_SAT_EN.
module vx_mem_perf_monitor #(
   parameter int  NUM_CH    = 2,
   parameter int  NUM_LANES = 4,
   parameter int  CTR_BITS  = 44,
   parameter int  PEND_BITS = 16,
   parameter int  REQ_DELAY = 1,
   localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          clear,
   input  logic [NUM_CH-1:0]             req_valid,
   input  logic [NUM_CH-1:0]             req_ready,
   input  logic [NUM_CH-1:0]             req_rw,
   input  logic [NUM_CH*NUM_LANES-1:0]   req_mask,
   input  logic [NUM_CH-1:0]             rsp_valid,
   input  logic [NUM_CH-1:0]             rsp_ready,
   input  logic [NUM_CH*NUM_LANES-1:0]   rsp_mask,
   input  logic [SEL_W-1:0]              rd_sel,
   output logic [CTR_BITS-1:0]           rd_reads,
   output logic [CTR_BITS-1:0]           rd_writes,
   output logic [CTR_BITS-1:0]           rd_latency,
   output logic [PEND_BITS-1:0]          rd_pending,
   output logic [PEND_BITS-1:0]          rd_peak,
   output logic [NUM_CH-1:0]             underflow
);

   localparam int CNT_W = $clog2(NUM_LANES + 1);
   localparam int PX_W  = PEND_BITS + 2;

   function automatic logic [CNT_W-1:0] popcount(input logic [NUM_LANES-1:0] mask);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         n = n + CNT_W'(mask[i]);
      end
      return n;
   endfunction

   function automatic logic [CTR_BITS-1:0] ctr_add(input logic [CTR_BITS-1:0] a,
                                                   input logic [CTR_BITS-1:0] b);
`ifdef MEM_PERF_SAT_EN
      logic [CTR_BITS:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum[CTR_BITS]) begin
         return '1;
      end else begin
         return sum[CTR_BITS-1:0];
      end
`else
      return a + b;
`endif
   endfunction

   logic [CTR_BITS-1:0]  reads_a   [NUM_CH];
   logic [CTR_BITS-1:0]  writes_a  [NUM_CH];
   logic [CTR_BITS-1:0]  latency_a [NUM_CH];
   logic [PEND_BITS-1:0] pending_a [NUM_CH];
   logic [PEND_BITS-1:0] peak_a    [NUM_CH];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic                 req_fire_s;
      logic [CNT_W-1:0]     rd_now_s;
      logic [CNT_W-1:0]     wr_now_s;
      logic [CNT_W-1:0]     rsp_s;
      logic [CNT_W-1:0]     rd_use_s;
      logic [CNT_W-1:0]     wr_use_s;
      logic [PX_W-1:0]      pend_raw_s;
      logic [PEND_BITS-1:0] pend_next_s;
      logic                 uf_hit_s;
      logic [CTR_BITS-1:0]  reads_r;
      logic [CTR_BITS-1:0]  writes_r;
      logic [CTR_BITS-1:0]  latency_r;
      logic [PEND_BITS-1:0] pending_r;
      logic [PEND_BITS-1:0] peak_r;
      logic                 uf_r;

      // Lane counts of this cycle's fired request and accepted response
      always_comb begin
         req_fire_s = req_valid[c] & req_ready[c];
         rd_now_s   = '0;
         wr_now_s   = '0;
         if (req_fire_s && req_rw[c]) begin
            wr_now_s = popcount(req_mask[c*NUM_LANES +: NUM_LANES]);
         end else if (req_fire_s) begin
            rd_now_s = popcount(req_mask[c*NUM_LANES +: NUM_LANES]);
         end else begin
            rd_now_s = '0;
            wr_now_s = '0;
         end
         if (rsp_valid[c] && rsp_ready[c]) begin
            rsp_s = popcount(rsp_mask[c*NUM_LANES +: NUM_LANES]);
         end else begin
            rsp_s = '0;
         end
      end

      if (REQ_DELAY != 0) begin : g_dly
         logic [CNT_W-1:0] rd_dly_r;
         logic [CNT_W-1:0] wr_dly_r;

         // Request lane counts staged one cycle; responses bypass this stage
         always_ff @(posedge clk) begin
            if (reset || clear) begin
               rd_dly_r <= '0;
               wr_dly_r <= '0;
            end else begin
               rd_dly_r <= rd_now_s;
               wr_dly_r <= wr_now_s;
            end
         end

         assign rd_use_s = rd_dly_r;
         assign wr_use_s = wr_dly_r;
      end else begin : g_nodly
         assign rd_use_s = rd_now_s;
         assign wr_use_s = wr_now_s;
      end

      // Two extra bits: the top bit flags a negative result, the next one overflow
      always_comb begin
         pend_raw_s = {2'b00, pending_r} + PX_W'(rd_use_s) - PX_W'(rsp_s);
         uf_hit_s   = pend_raw_s[PX_W-1];
         if (pend_raw_s[PX_W-1]) begin
            pend_next_s = '0;
         end else if (pend_raw_s[PEND_BITS]) begin
            pend_next_s = '1;
         end else begin
            pend_next_s = pend_raw_s[PEND_BITS-1:0];
         end
      end

      // Counter state; every update uses start-of-cycle values
      always_ff @(posedge clk) begin
         if (reset || clear) begin
            reads_r   <= '0;
            writes_r  <= '0;
            latency_r <= '0;
            pending_r <= '0;
            peak_r    <= '0;
            uf_r      <= 1'b0;
         end else begin
            reads_r   <= ctr_add(reads_r, CTR_BITS'(rd_use_s));
            writes_r  <= ctr_add(writes_r, CTR_BITS'(wr_use_s));
            latency_r <= ctr_add(latency_r, CTR_BITS'(pending_r));
            pending_r <= pend_next_s;
            peak_r    <= (pend_next_s > peak_r) ? pend_next_s : peak_r;
            uf_r      <= uf_r | uf_hit_s;
         end
      end

      assign reads_a[c]   = reads_r;
      assign writes_a[c]  = writes_r;
      assign latency_a[c] = latency_r;
      assign pending_a[c] = pending_r;
      assign peak_a[c]    = peak_r;
      assign underflow[c] = uf_r;
   end

   logic [CTR_BITS-1:0]  sel_reads_s;
   logic [CTR_BITS-1:0]  sel_writes_s;
   logic [CTR_BITS-1:0]  sel_latency_s;
   logic [PEND_BITS-1:0] sel_pending_s;
   logic [PEND_BITS-1:0] sel_peak_s;

   // AND-OR channel mux; an out-of-range select matches nothing and yields zeros
   always_comb begin
      sel_reads_s   = '0;
      sel_writes_s  = '0;
      sel_latency_s = '0;
      sel_pending_s = '0;
      sel_peak_s    = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         sel_reads_s   = sel_reads_s   | ({CTR_BITS{rd_sel == SEL_W'(c)}}  & reads_a[c]);
         sel_writes_s  = sel_writes_s  | ({CTR_BITS{rd_sel == SEL_W'(c)}}  & writes_a[c]);
         sel_latency_s = sel_latency_s | ({CTR_BITS{rd_sel == SEL_W'(c)}}  & latency_a[c]);
         sel_pending_s = sel_pending_s | ({PEND_BITS{rd_sel == SEL_W'(c)}} & pending_a[c]);
         sel_peak_s    = sel_peak_s    | ({PEND_BITS{rd_sel == SEL_W'(c)}} & peak_a[c]);
      end
   end

   // Registered readout
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         rd_reads   <= '0;
         rd_writes  <= '0;
         rd_latency <= '0;
         rd_pending <= '0;
         rd_peak    <= '0;
      end else begin
         rd_reads   <= sel_reads_s;
         rd_writes  <= sel_writes_s;
         rd_latency <= sel_latency_s;
         rd_pending <= sel_pending_s;
         rd_peak    <= sel_peak_s;
      end
   end

endmodule

// File: tb/tb_vx_mem_perf_monitor.sv
// Directed bench for vx_mem_perf_monitor: a 3-channel REQ_DELAY=1 instance and a small
// 1-channel REQ_DELAY=0 instance with 4-bit counters for wrap/saturation.
module tb_vx_mem_perf_monitor;

`ifdef MEM_PERF_SAT_EN
   localparam longint WX = 15;
   localparam longint LX = 15;
`else
   localparam longint WX = 2;
   localparam longint LX = 2;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, clear;
   logic [2:0]  req_valid, req_ready, req_rw, rsp_valid, rsp_ready;
   logic [11:0] req_mask, rsp_mask;
   logic [1:0]  rd_sel;
   logic [43:0] rd_reads, rd_writes, rd_latency;
   logic [15:0] rd_pending, rd_peak;
   logic [2:0]  underflow;

   logic        s_clear, s_req_valid, s_req_ready, s_req_rw, s_rsp_valid, s_rsp_ready;
   logic [3:0]  s_req_mask, s_rsp_mask;
   logic        s_rd_sel;
   logic [3:0]  s_rd_reads, s_rd_writes, s_rd_latency;
   logic [2:0]  s_rd_pending, s_rd_peak;
   logic        s_underflow;

   vx_mem_perf_monitor #(.NUM_CH(3), .NUM_LANES(4), .CTR_BITS(44), .PEND_BITS(16), .REQ_DELAY(1)) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_mask(req_mask),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_mask(rsp_mask),
      .rd_sel(rd_sel), .rd_reads(rd_reads), .rd_writes(rd_writes), .rd_latency(rd_latency),
      .rd_pending(rd_pending), .rd_peak(rd_peak), .underflow(underflow)
   );

   vx_mem_perf_monitor #(.NUM_CH(1), .NUM_LANES(4), .CTR_BITS(4), .PEND_BITS(3), .REQ_DELAY(0)) sdut (
      .clk(clk), .reset(reset), .clear(s_clear),
      .req_valid(s_req_valid), .req_ready(s_req_ready), .req_rw(s_req_rw), .req_mask(s_req_mask),
      .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_mask(s_rsp_mask),
      .rd_sel(s_rd_sel), .rd_reads(s_rd_reads), .rd_writes(s_rd_writes), .rd_latency(s_rd_latency),
      .rd_pending(s_rd_pending), .rd_peak(s_rd_peak), .underflow(s_underflow)
   );

   typedef struct packed {
      logic        dut;
      logic [43:0] reads;
      logic [43:0] writes;
      logic [43:0] lat;
      logic [15:0] pend;
      logic [15:0] peak;
   } exp_t;

   exp_t  sb_q[$];
   string tag_q[$];
   int    checks   = 0;
   int    failures = 0;

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic idle();
      req_valid = 3'b000; req_ready = 3'b000; req_rw = 3'b000; req_mask = 12'h000;
      rsp_valid = 3'b000; rsp_ready = 3'b000; rsp_mask = 12'h000;
      s_req_valid = 1'b0; s_req_ready = 1'b0; s_req_rw = 1'b0; s_req_mask = 4'h0;
      s_rsp_valid = 1'b0; s_rsp_ready = 1'b0; s_rsp_mask = 4'h0;
   endtask

   task automatic set_req(input int ch, input logic rw, input logic [3:0] m);
      req_valid[ch] = 1'b1; req_ready[ch] = 1'b1; req_rw[ch] = rw;
      req_mask[ch*4 +: 4] = m;
   endtask

   task automatic set_rsp(input int ch, input logic [3:0] m);
      rsp_valid[ch] = 1'b1; rsp_ready[ch] = 1'b1;
      rsp_mask[ch*4 +: 4] = m;
   endtask

   task automatic s_set(input logic rw, input logic [3:0] m);
      s_req_valid = 1'b1; s_req_ready = 1'b1; s_req_rw = rw; s_req_mask = m;
   endtask

   // Drive the select and push the values the readout must show after the next edge
   task automatic expect_rd(input string tag, input logic d, input logic [1:0] sel,
                            input longint r, input longint w, input longint l,
                            input longint p, input longint k);
      exp_t e;
      if (d) s_rd_sel = sel[0];
      else   rd_sel   = sel;
      e.dut = d; e.reads = 44'(r); e.writes = 44'(w); e.lat = 44'(l);
      e.pend = 16'(p); e.peak = 16'(k);
      sb_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic check_rd();
      exp_t  e;
      string t;
      chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         t = tag_q.pop_front();
         if (e.dut) begin
            chk({t, ".reads"},   64'(s_rd_reads),   64'(e.reads));
            chk({t, ".writes"},  64'(s_rd_writes),  64'(e.writes));
            chk({t, ".latency"}, 64'(s_rd_latency), 64'(e.lat));
            chk({t, ".pending"}, 64'(s_rd_pending), 64'(e.pend));
            chk({t, ".peak"},    64'(s_rd_peak),    64'(e.peak));
         end else begin
            chk({t, ".reads"},   64'(rd_reads),   64'(e.reads));
            chk({t, ".writes"},  64'(rd_writes),  64'(e.writes));
            chk({t, ".latency"}, 64'(rd_latency), 64'(e.lat));
            chk({t, ".pending"}, 64'(rd_pending), 64'(e.pend));
            chk({t, ".peak"},    64'(rd_peak),    64'(e.peak));
         end
      end
   endtask

   task automatic peek(input string tag, input logic d, input logic [1:0] sel,
                       input longint r, input longint w, input longint l,
                       input longint p, input longint k);
      expect_rd(tag, d, sel, r, w, l, p, k);
      cyc();
      check_rd();
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; s_clear = 1'b0; rd_sel = 2'd0; s_rd_sel = 1'b0;
      idle();
      set_req(0, 1'b0, 4'b1111);   // traffic under reset must leave no trace
      @(negedge clk);
      cyc();
      cyc();
      chk("reset.reads",     64'(rd_reads),   64'd0);
      chk("reset.latency",   64'(rd_latency), 64'd0);
      chk("reset.peak",      64'(rd_peak),    64'd0);
      chk("reset.underflow", 64'(underflow),  64'd0);
      chk("reset.s_writes",  64'(s_rd_writes), 64'd0);
      reset = 1'b0;
      idle();

      // Basic read on ch0 through the request delay stage
      set_req(0, 1'b0, 4'b1011);
      cyc();
      idle();
      cyc();
      peek("t1_after_hit", 1'b0, 2'd0, 3, 0, 0, 3, 3);
      set_rsp(0, 4'b0011);
      expect_rd("t1_rsp_cycle", 1'b0, 2'd0, 3, 0, 3, 3, 3);
      cyc();
      check_rd();
      idle();
      peek("t1_after_rsp", 1'b0, 2'd0, 3, 0, 6, 1, 3);
      chk("t1.underflow", 64'(underflow), 64'd0);

      // ch1 writes: five fires plus one stalled cycle
      for (int i = 0; i < 6; i++) begin
         set_req(1, 1'b1, 4'b1111);
         if (i == 2) req_ready[1] = 1'b0;
         cyc();
      end
      idle();
      cyc();
      peek("t2_ch1", 1'b0, 2'd1, 0, 20, 0, 0, 0);

      // Clear collides with a ch0 read fire
      clear = 1'b1;
      set_req(0, 1'b0, 4'b1111);
      expect_rd("t4_clear_rdout", 1'b0, 2'd1, 0, 0, 0, 0, 0);
      cyc();
      check_rd();
      clear = 1'b0;
      idle();
      peek("t4_ch0_after", 1'b0, 2'd0, 0, 0, 0, 0, 0);
      peek("t4_ch0_next",  1'b0, 2'd0, 0, 0, 0, 0, 0);
      peek("t4_ch1",       1'b0, 2'd1, 0, 0, 0, 0, 0);

      // Underflow on ch0, then a same-cycle hit/response on ch2
      set_rsp(0, 4'b0001);
      cyc();
      idle();
      chk("t3.underflow_set", 64'(underflow), 64'b001);
      peek("t3_pend", 1'b0, 2'd0, 0, 0, 0, 0, 0);
      chk("t3.underflow_sticky", 64'(underflow), 64'b001);
      set_req(2, 1'b0, 4'b0011);
      cyc();
      idle();
      set_rsp(2, 4'b0011);
      cyc();
      idle();
      chk("t3.no_uf_ch2", 64'(underflow), 64'b001);
      peek("t3_ch2", 1'b0, 2'd2, 2, 0, 0, 0, 0);
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      chk("t3.underflow_cleared", 64'(underflow), 64'd0);

      // Overlapping requests/responses, out-of-range select, reset mid-traffic
      set_req(0, 1'b0, 4'b1111);
      cyc();
      idle();
      set_req(0, 1'b0, 4'b0110);
      cyc();
      idle();
      set_rsp(0, 4'b0111);
      cyc();
      idle();
      peek("t6_oob", 1'b0, 2'd3, 0, 0, 0, 0, 0);
      peek("t6_ch0", 1'b0, 2'd0, 6, 0, 7, 3, 4);
      set_req(0, 1'b0, 4'b1111);
      set_rsp(1, 4'b1111);
      rd_sel = 2'd0;
      reset = 1'b1;
      cyc();
      chk("t6_rst.reads",     64'(rd_reads),   64'd0);
      chk("t6_rst.latency",   64'(rd_latency), 64'd0);
      chk("t6_rst.pending",   64'(rd_pending), 64'd0);
      chk("t6_rst.peak",      64'(rd_peak),    64'd0);
      chk("t6_rst.underflow", 64'(underflow),  64'd0);
      reset = 1'b0;
      idle();
      peek("t6_post_reset", 1'b0, 2'd0, 0, 0, 0, 0, 0);

      // Small instance: 4-bit counter wrap/saturate, 3-bit pending saturation
      s_set(1'b1, 4'b1111);
      repeat (3) cyc();
      s_set(1'b1, 4'b0011);
      cyc();
      idle();
      peek("t5_w14", 1'b1, 2'd0, 0, 14, 0, 0, 0);
      s_set(1'b1, 4'b1111);
      cyc();
      idle();
      peek("t5_wrap", 1'b1, 2'd0, 0, WX, 0, 0, 0);
      s_set(1'b0, 4'b1111);
      cyc();
      cyc();
      idle();
      peek("t5_psat",    1'b1, 2'd0, 8, WX, 4,  7, 7);
      peek("t5_lat11",   1'b1, 2'd0, 8, WX, 11, 7, 7);
      peek("t5_latwrap", 1'b1, 2'd0, 8, WX, LX, 7, 7);
      peek("t5_oob",     1'b1, 2'd1, 0, 0, 0, 0, 0);
      chk("t5.underflow", 64'(s_underflow), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
